// File: rtl/exec_unit.sv
// exec_unit: multi-cycle execution unit responding to the control unit's
// execute-phase request. Captures op/a/b on start, runs single-cycle
// logic/arithmetic ops or iterative shift (1 bit/cycle), Booth radix-2 signed
// multiply and restoring unsigned divide, then pulses ex for one cycle.
//
// Optional feature macro: EXEC_UNIT_MULDIV_EN
//   defined   -> MUL (op 8) and DIV (op 9) datapaths are built
//   undefined -> ops 8 and 9 complete as illegal ops (L = 1, results 0, err = 1)
//
// Ports:
//   clk     in  clock, rising edge
//   rst     in  synchronous active-high reset
//   start   in  execute request (level, held until ex is seen)
//   op      in  operation code, sampled with start
//   a, b    in  operands, sampled with start
//   res_lo  out primary result
//   res_hi  out product high half / remainder, 0 otherwise
//   flags   out {V,C,N,Z}
//   ex      out one-cycle done pulse
//   busy    out high while iterating
//   err     out illegal op / divide by zero, held until the next ex
module exec_unit #(
    parameter int unsigned W  = 16,
    parameter int unsigned SW = $clog2(W)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [3:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] res_lo,
    output logic [W-1:0] res_hi,
    output logic [3:0]   flags,
    output logic         ex,
    output logic         busy,
    output logic         err
);

    localparam int unsigned CW = SW + 1;  // holds counts up to W

    localparam logic [3:0] OpAdd = 4'd0;
    localparam logic [3:0] OpSub = 4'd1;
    localparam logic [3:0] OpAnd = 4'd2;
    localparam logic [3:0] OpOr  = 4'd3;
    localparam logic [3:0] OpXor = 4'd4;
    localparam logic [3:0] OpNot = 4'd5;
    localparam logic [3:0] OpShl = 4'd6;
    localparam logic [3:0] OpShr = 4'd7;
    localparam logic [3:0] OpMul = 4'd8;
    localparam logic [3:0] OpDiv = 4'd9;
    localparam logic [3:0] OpCmp = 4'd10;

    typedef enum logic [1:0] {StIdle, StBusy, StRel} state_e;

    function automatic logic op_legal(input logic [3:0] o);
`ifdef EXEC_UNIT_MULDIV_EN
        return o <= OpCmp;
`else
        return (o <= OpCmp) && (o != OpMul) && (o != OpDiv);
`endif
    endfunction

    state_e         state_q;
    logic [3:0]     op_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [W-1:0]   lo_q;    // shift data / Booth multiplier / dividend-quotient
    logic           sc_q;    // last bit shifted out
    logic [CW-1:0]  cnt_q;   // remaining iterations

`ifdef EXEC_UNIT_MULDIV_EN
    logic [W:0]     acc_q;   // Booth accumulator / divider remainder
    logic           qm1_q;   // Booth q[-1]
    logic [W:0]     step_acc;
    logic           step_qm1;
    logic [W:0]     m_ext;
    logic [W:0]     booth_sum;
    logic [W:0]     div_r;
    logic [W+1:0]   div_diff;
`endif

    logic [W-1:0]   step_lo;
    logic           step_sc;
    logic [CW-1:0]  load_cnt;

    logic [W:0]     sum;
    logic [W:0]     diff;
    logic           add_v;
    logic           sub_v;
    logic [W-1:0]   fin_lo;
    logic [W-1:0]   fin_hi;
    logic [W-1:0]   flag_src;
    logic           fin_v;
    logic           fin_c;
    logic           fin_n;
    logic           fin_z;
    logic           fin_err;
    logic           illegal;
    logic [3:0]     fin_flags;

    // Iteration count loaded at capture; zero means finish on the next edge.
    always_comb begin
        load_cnt = '0;
        if (op_legal(op)) begin
            if (op == OpShl || op == OpShr) begin
                load_cnt = {1'b0, b[SW-1:0]};
            end else if (op == OpMul || (op == OpDiv && b != '0)) begin
                load_cnt = CW'(W);
            end
        end
    end

    // One iteration of the active multi-cycle op.
    always_comb begin
        step_lo = lo_q;
        step_sc = sc_q;
`ifdef EXEC_UNIT_MULDIV_EN
        step_acc  = acc_q;
        step_qm1  = qm1_q;
        m_ext     = {a_q[W-1], a_q};
        booth_sum = acc_q;
        div_r     = {acc_q[W-1:0], lo_q[W-1]};
        div_diff  = {1'b0, div_r} - {2'b00, b_q};
`endif
        case (op_q)
            OpShl: begin
                step_sc = lo_q[W-1];
                step_lo = {lo_q[W-2:0], 1'b0};
            end
            OpShr: begin
                step_sc = lo_q[0];
                step_lo = {1'b0, lo_q[W-1:1]};
            end
`ifdef EXEC_UNIT_MULDIV_EN
            OpMul: begin
                case ({lo_q[0], qm1_q})
                    2'b01:   booth_sum = acc_q + m_ext;
                    2'b10:   booth_sum = acc_q - m_ext;
                    default: booth_sum = acc_q;
                endcase
                // Arithmetic right shift of {acc, q, q-1}.
                step_acc = {booth_sum[W], booth_sum[W:1]};
                step_lo  = {booth_sum[0], lo_q[W-1:1]};
                step_qm1 = lo_q[0];
            end
            OpDiv: begin
                if (!div_diff[W+1]) begin
                    step_acc = div_diff[W:0];
                    step_lo  = {lo_q[W-2:0], 1'b1};
                end else begin
                    step_acc = div_r;
                    step_lo  = {lo_q[W-2:0], 1'b0};
                end
            end
`endif
            default: ;
        endcase
    end

    // Final results written at completion.
    always_comb begin
        sum      = {1'b0, a_q} + {1'b0, b_q};
        diff     = {1'b0, a_q} - {1'b0, b_q};
        add_v    = (a_q[W-1] == b_q[W-1]) && (sum[W-1] != a_q[W-1]);
        sub_v    = (a_q[W-1] != b_q[W-1]) && (diff[W-1] != a_q[W-1]);
        fin_lo   = '0;
        fin_hi   = '0;
        fin_v    = 1'b0;
        fin_c    = 1'b0;
        fin_err  = 1'b0;
        illegal  = !op_legal(op_q);
        case (op_q)
            OpAdd: begin
                fin_lo = sum[W-1:0];
                fin_c  = sum[W];
                fin_v  = add_v;
            end
            OpSub: begin
                fin_lo = diff[W-1:0];
                fin_c  = diff[W];
                fin_v  = sub_v;
            end
            OpAnd: fin_lo = a_q & b_q;
            OpOr:  fin_lo = a_q | b_q;
            OpXor: fin_lo = a_q ^ b_q;
            OpNot: fin_lo = ~a_q;
            OpShl, OpShr: begin
                fin_lo = lo_q;
                fin_c  = sc_q;
            end
`ifdef EXEC_UNIT_MULDIV_EN
            OpMul: begin
                fin_lo = lo_q;
                fin_hi = acc_q[W-1:0];
            end
            OpDiv: begin
                if (b_q == '0) begin
                    fin_lo  = '1;
                    fin_hi  = a_q;
                    fin_err = 1'b1;
                end else begin
                    fin_lo = lo_q;
                    fin_hi = acc_q[W-1:0];
                end
            end
`endif
            OpCmp: begin
                // Results untouched, only flags reflect a - b.
                fin_lo = res_lo;
                fin_hi = res_hi;
                fin_c  = diff[W];
                fin_v  = sub_v;
            end
            default: fin_err = 1'b1;
        endcase
        flag_src = (op_q == OpCmp) ? diff[W-1:0] : fin_lo;
        fin_n    = (op_q == OpMul) ? fin_hi[W-1] : flag_src[W-1];
        fin_z    = (op_q == OpMul) ? ({fin_hi, fin_lo} == '0) : (flag_src == '0);
        fin_flags = illegal ? 4'b0000 : {fin_v, fin_c, fin_n, fin_z};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            res_lo  <= '0;
            res_hi  <= '0;
            flags   <= '0;
            ex      <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            lo_q    <= '0;
            sc_q    <= 1'b0;
            cnt_q   <= '0;
`ifdef EXEC_UNIT_MULDIV_EN
            acc_q   <= '0;
            qm1_q   <= 1'b0;
`endif
        end else begin
            ex <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        op_q    <= op;
                        a_q     <= a;
                        b_q     <= b;
                        lo_q    <= (op == OpMul) ? b : a;
                        sc_q    <= 1'b0;
                        cnt_q   <= load_cnt;
`ifdef EXEC_UNIT_MULDIV_EN
                        acc_q   <= '0;
                        qm1_q   <= 1'b0;
`endif
                        busy    <= 1'b1;
                        state_q <= StBusy;
                    end
                end
                StBusy: begin
                    if (!start) begin
                        // Abort: drop the iteration, keep visible results.
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                        lo_q  <= step_lo;
                        sc_q  <= step_sc;
`ifdef EXEC_UNIT_MULDIV_EN
                        acc_q <= step_acc;
                        qm1_q <= step_qm1;
`endif
                    end else begin
                        res_lo  <= fin_lo;
                        res_hi  <= fin_hi;
                        flags   <= fin_flags;
                        err     <= fin_err;
                        ex      <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= StRel;
                    end
                end
                StRel: begin
                    if (!start) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_exec_unit.sv
module tb_exec_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res_lo;
    logic [15:0] res_hi;
    logic [3:0]  flags;
    logic        ex;
    logic        busy;
    logic        err;

    exec_unit #(.W(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .res_lo (res_lo),
        .res_hi (res_hi),
        .flags  (flags),
        .ex     (ex),
        .busy   (busy),
        .err    (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] lo;
        logic [15:0] hi;
        logic [3:0]  fl;
        logic        er;
        int          e0;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [15:0] prev_lo = '0;
    logic [15:0] prev_hi = '0;
    logic [3:0]  prev_fl = '0;
    logic        prev_er = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: compare every ex pulse against the oldest expected response.
    always @(negedge clk) begin
        if (ex === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_ex: got ex=1 expected no pulse (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("res_lo", 64'(res_lo), 64'(e.lo));
                check("res_hi", 64'(res_hi), 64'(e.hi));
                check("flags", 64'(flags), 64'(e.fl));
                check("err", 64'(err), 64'(e.er));
                check("latency", 64'(cyc - e.e0), 64'(e.lat));
            end
        end
    end

    localparam logic [3:0] OpAdd = 4'd0;
    localparam logic [3:0] OpSub = 4'd1;
    localparam logic [3:0] OpAnd = 4'd2;
    localparam logic [3:0] OpOr  = 4'd3;
    localparam logic [3:0] OpXor = 4'd4;
    localparam logic [3:0] OpNot = 4'd5;
    localparam logic [3:0] OpShl = 4'd6;
    localparam logic [3:0] OpShr = 4'd7;
    localparam logic [3:0] OpMul = 4'd8;
    localparam logic [3:0] OpDiv = 4'd9;
    localparam logic [3:0] OpCmp = 4'd10;

    // Issue one request, hold start 'hold' extra cycles after ex, then release.
    task automatic issue(input logic [3:0] o, input logic [15:0] ia, input logic [15:0] ib,
                         input logic [15:0] elo, input logic [15:0] ehi,
                         input logic [3:0] efl, input logic eer, input int lat,
                         input int hold);
        exp_t e;
        bit   got;
        int   busy_cnt;
        int   extra_ex;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = ia;
        b     = ib;
        e.lo = elo; e.hi = ehi; e.fl = efl; e.er = eer; e.e0 = cyc + 1; e.lat = lat;
        exp_q.push_back(e);
        prev_lo = elo; prev_hi = ehi; prev_fl = efl; prev_er = eer;
        got      = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            // Operands are scrambled after capture; the result must not care.
            a = ~ia;
            b = ib ^ 16'h5a5a;
            if (ex === 1'b1) got = 1'b1;
            else if (busy === 1'b1) busy_cnt++;
        end
        if (!got) begin
            n_checks++;
            n_errors++;
            $display("FAIL ex_timeout: got no ex expected ex after %0d cycles (op %0d)", lat, o);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else begin
            check("busy_cycles", 64'(busy_cnt), 64'(lat));
        end
        extra_ex = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (ex === 1'b1) extra_ex++;
        end
        if (hold > 0) check("single_ex_on_hold", 64'(extra_ex), 64'(0));
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_held(input string tag);
        check({tag, "_res_lo"}, 64'(res_lo), 64'(prev_lo));
        check({tag, "_res_hi"}, 64'(res_hi), 64'(prev_hi));
        check({tag, "_flags"}, 64'(flags), 64'(prev_fl));
        check({tag, "_err"}, 64'(err), 64'(prev_er));
        check({tag, "_busy"}, 64'(busy), 64'(0));
    endtask

    initial begin
        int seen;
        rst   = 1'b1;
        start = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        check("rst_outputs", 64'({res_lo, res_hi, flags, ex, busy, err}), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        issue(OpAdd, 16'h7fff, 16'h0001, 16'h8000, 16'h0000, 4'b1010, 1'b0, 1, 0);
        issue(OpSub, 16'h0003, 16'h0005, 16'hfffe, 16'h0000, 4'b0110, 1'b0, 1, 0);
        issue(OpShl, 16'h8001, 16'h0001, 16'h0002, 16'h0000, 4'b0100, 1'b0, 2, 0);
        issue(OpShr, 16'h0003, 16'h0002, 16'h0000, 16'h0000, 4'b0101, 1'b0, 3, 0);
        issue(OpShl, 16'h1234, 16'h0010, 16'h1234, 16'h0000, 4'b0000, 1'b0, 1, 0);
        issue(OpAnd, 16'hf0f0, 16'h0ff0, 16'h00f0, 16'h0000, 4'b0000, 1'b0, 1, 0);
        issue(OpOr,  16'h1200, 16'h0034, 16'h1234, 16'h0000, 4'b0000, 1'b0, 1, 0);
        issue(OpXor, 16'hf0f0, 16'hf0f0, 16'h0000, 16'h0000, 4'b0001, 1'b0, 1, 0);
        issue(OpNot, 16'h00ff, 16'h0000, 16'hff00, 16'h0000, 4'b0010, 1'b0, 1, 0);
        issue(OpAdd, 16'hffff, 16'h0001, 16'h0000, 16'h0000, 4'b0101, 1'b0, 1, 0);
`ifdef EXEC_UNIT_MULDIV_EN
        issue(OpMul, 16'hfffd, 16'h0007, 16'hffeb, 16'hffff, 4'b0010, 1'b0, 17, 0);
        issue(OpDiv, 16'h1234, 16'h0000, 16'hffff, 16'h1234, 4'b0010, 1'b1, 1, 0);
        issue(OpDiv, 16'd100, 16'd7, 16'h000e, 16'h0002, 4'b0000, 1'b0, 17, 0);
`else
        issue(OpMul, 16'hfffd, 16'h0007, 16'h0000, 16'h0000, 4'b0000, 1'b1, 1, 0);
        issue(OpDiv, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 4'b0000, 1'b1, 1, 0);
        issue(OpDiv, 16'd100, 16'd7, 16'h0000, 16'h0000, 4'b0000, 1'b1, 1, 0);
`endif
        // CMP leaves results as the previous op wrote them.
        issue(OpCmp, 16'h8000, 16'h0001, prev_lo, prev_hi, 4'b1000, 1'b0, 1, 0);
        issue(4'd12, 16'h1111, 16'h2222, 16'h0000, 16'h0000, 4'b0000, 1'b1, 1, 0);
        issue(OpAdd, 16'h0001, 16'h0002, 16'h0003, 16'h0000, 4'b0000, 1'b0, 1, 10);

        // Abort: start sampled low at edge 5 of a long op.
        @(negedge clk);
        start = 1'b1;
`ifdef EXEC_UNIT_MULDIV_EN
        op = OpMul; a = 16'h0002; b = 16'h0003;
`else
        op = OpShl; a = 16'h0001; b = 16'h000f;
`endif
        repeat (5) @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (ex === 1'b1) seen++;
        end
        check("abort_no_ex", 64'(seen), 64'(0));
        check_held("abort");

        // Reset at edge 5 of a long op.
        @(negedge clk);
        start = 1'b1;
`ifdef EXEC_UNIT_MULDIV_EN
        op = OpDiv; a = 16'd100; b = 16'd7;
`else
        op = OpShl; a = 16'h0001; b = 16'h000c;
`endif
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midop_rst_outputs", 64'({res_lo, res_hi, flags, ex, busy, err}), 64'(0));
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        issue(OpSub, 16'h8000, 16'h0001, 16'h7fff, 16'h0000, 4'b1000, 1'b0, 1, 0);

        repeat (3) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
